// File: rtl/fir_decim_fifo.sv
// Integrate-and-dump decimator averaging each block of 2^LOG2_DECIM FIR samples into one word, buffered in a FWFT FIFO.
// Latency: result is visible on dout one cycle after the last sample of its block (when the FIFO was empty).
// Backpressure: none toward the FIR; out_ready only drains the FIFO, and results arriving while full are dropped (ovf).
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_en, din        FIR sample strobe and unsigned sample
//   out_valid, dout   FIFO non-empty and head word (0 when empty)
//   out_ready         consumer pops the head word this cycle
//   fifo_level        words stored, 0..DEPTH
//   ovf               sticky: a result was discarded because the FIFO was full
//   drop_cnt          saturating count of discarded results
// Build option: define FIR_DECIM_DROP_CNT_EN to build the drop_cnt register; otherwise drop_cnt is tied to 0.
module fir_decim_fifo #(
  parameter int DW         = 11,
  parameter int LOG2_DECIM = 2,
  parameter int DEPTH      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_en,
  input  logic [DW-1:0]            din,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            dout,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     ovf,
  output logic [15:0]              drop_cnt
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;
  localparam int ACW = DW + LOG2_DECIM;

  localparam logic [LW-1:0]         FULL_L = LW'(DEPTH);
  localparam logic [LW-1:0]         ONE_L  = LW'(1);
  localparam logic [AW-1:0]         ONE_A  = AW'(1);
  localparam logic [LOG2_DECIM-1:0] ONE_P  = LOG2_DECIM'(1);

  logic [LOG2_DECIM-1:0] phase_q, phase_d;
  logic [ACW-1:0]        acc_q, acc_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  ovf_q, ovf_d;
  logic [DW-1:0]         mem_q [DEPTH];

  logic [ACW-1:0] sum;
  logic [DW-1:0]  res_dat;
  logic           last, res_vld, full, push, pop, drop;

  always_comb begin
    // Accumulator is wide enough for a full block of max-scale samples, so no wrap.
    sum      = acc_q + ACW'(din);
    res_dat  = DW'(sum >> LOG2_DECIM);
    last     = (phase_q == '1);
    res_vld  = in_en & last;
    full     = (level_q == FULL_L);
    pop      = out_valid & out_ready;
    // A pop on the same edge frees the slot, so a full FIFO can still take the result.
    push     = res_vld & (~full | pop);
    drop     = res_vld & full & ~pop;

    phase_d  = in_en ? phase_q + ONE_P : phase_q;
    acc_d    = acc_q;
    if (in_en) begin
      acc_d = last ? '0 : sum;
    end

    wr_ptr_d = push ? wr_ptr_q + ONE_A : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + ONE_A : rd_ptr_q;
    level_d  = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + ONE_L;
      2'b01:   level_d = level_q - ONE_L;
      default: level_d = level_q;
    endcase
    ovf_d    = ovf_q | drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q  <= '0;
      acc_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      acc_q    <= acc_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: dout is gated by out_valid, which follows the reset level.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= res_dat;
    end
  end

  assign out_valid  = (level_q != '0);
  assign dout       = out_valid ? mem_q[rd_ptr_q] : '0;
  assign fifo_level = level_q;
  assign ovf        = ovf_q;

`ifdef FIR_DECIM_DROP_CNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt_q <= 16'h0000;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
`else
  assign drop_cnt = 16'h0000;
`endif

endmodule

// File: doc/fir_decim_fifo.md
# fir_decim_fifo

Integrate-and-dump decimator with an output FIFO, sitting directly downstream of the synchronous 16-tap FIR. It consumes the FIR's 11-bit output on every enabled cycle and averages each block of 2^LOG2_DECIM consecutive samples into one output word. Results are buffered in a small first-word-fall-through FIFO and drained by the consumer over a valid/ready handshake.

## Interface
- DW, 11, sample width; matches FIR `dout`.
- LOG2_DECIM, 2, decimation factor = 2^LOG2_DECIM; legal range 1..4.
- DEPTH, 8, FIFO depth in words; power of 2, at least 2.
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_en  input  1  `din` is a valid FIR sample this cycle.
- din  input  DW  FIR output sample, unsigned.
- out_valid  output  1  FIFO non-empty; `dout` holds the head word.
- out_ready  input  1  consumer accepts the head word this cycle.
- dout  output  DW  head of FIFO; 0 when `out_valid` = 0.
- fifo_level  output  $clog2(DEPTH)+1  number of words stored, 0..DEPTH.
- ovf  output  1  sticky flag; a result was dropped because the FIFO was full.
- drop_cnt  output  16  count of dropped results (only with FIR_DECIM_DROP_CNT_EN).

## Operation
- **Phase counter:** LOG2_DECIM bits wide; increments on each cycle with `in_en` = 1 and wraps from 2^LOG2_DECIM−1 to 0. It holds while `in_en` = 0.
- **Accumulator:** DW+LOG2_DECIM bits, unsigned, so it cannot overflow.
  - When `in_en` = 1 and phase < last: acc <= acc + din.
  - When `in_en` = 1 and phase = last: result = (acc + din) >> LOG2_DECIM, truncating with no rounding. Push the result and set acc <= 0.
- **FIFO:** circular buffer with rd/wr pointers and a level counter.
  - A push occurs when a result is produced and either level < DEPTH or a pop happens in the same cycle.
  - A pop occurs when `out_valid` and `out_ready` are both 1.
- **Simultaneous push and pop:**
  - At any level, both take effect and the level is unchanged.
  - When full, the push is accepted because the pop frees the slot.
  - When empty, a push and pop cannot coincide, since `out_valid` = 0.
- **Overflow:** a result produced while full with no pop is discarded. Then `ovf` <= 1, and `drop_cnt` increments (if the macro is enabled). `ovf` is cleared only by `rst`.
- **Output:** `out_valid` = (level ≠ 0). `dout` = mem[rd_ptr] when `out_valid` = 1, else 0.
- **Ordering:** strict FIFO; results leave in production order.

## Timing
- **Reset:** on any rising edge with `rst` = 1:
  - phase = 0, acc = 0, pointers = 0, level = 0;
  - `out_valid` = 0, `dout` = 0, `ovf` = 0, `drop_cnt` = 0.
- **Reset mid-operation:** discards the partial accumulation and all FIFO contents. Reset takes priority over `in_en` and `out_ready`.
- **Latency:** the result enters the FIFO on the edge that samples the last block sample. If the FIFO was empty, `out_valid` = 1 and `dout` = result in the following cycle, i.e. 1 cycle after the final `din`.
- **Pop timing:** takes effect on the clock edge; the next head word is visible in the following cycle. Back-to-back pops drain one word per cycle.
- **Flags:** `fifo_level` and `ovf` are registered and update on the same edge as the push/pop that changes them.
- **Throughput:** input accepts one sample per cycle without stalling. There is no backpressure to the FIR, which has no handshake; loss is reported through `ovf`.

## Configuration
- Macro: FIR_DECIM_DROP_CNT_EN.
- **Defined:** `drop_cnt` is a 16-bit register that increments once per dropped result. It saturates at 16'hFFFF and resets to 0.
- **Undefined:** the register is not built; `drop_cnt` is tied to 16'h0000. `ovf` behaviour is identical in both cases.

## Test plan
Defaults unless noted (LOG2_DECIM = 2, DEPTH = 8).
- **Basic average:** reset; `in_en` = 1 with `din` = 100, 200, 300, 400 → next cycle `out_valid` = 1, `dout` = 250, `fifo_level` = 1. With `out_ready` = 1 for one cycle → `out_valid` = 0, `dout` = 0.
- **Truncation and full scale:** `din` = 1, 1, 1, 2 → `dout` = 1. Then `din` = 2047 ×4 → `dout` = 2047, with no accumulator wrap.
- **Overflow:** `out_ready` = 0, 36 samples of value 8 → `fifo_level` = 8, `ovf` = 1, `drop_cnt` = 1 (macro on) or 0 (macro off). Then `out_ready` = 1 → eight words of 8 drain on consecutive cycles, after which `out_valid` = 0.
- **Full with simultaneous pop:** FIFO at level 8; `out_ready` = 1 on the cycle the 9th result is produced → `fifo_level` stays 8, `ovf` stays 0, and the new word appears last in the drain order.
- **Enable gaps:** `din` = 40, (`in_en` = 0 ×3), 40, 40, (`in_en` = 0), 40 → exactly one result, `dout` = 40, with the phase held across the gaps.
- **Reset mid-block:** feed 2 samples of 1000, assert `rst` for 1 cycle, then 4 samples of 8 → `dout` = 8, with no contamination from before reset; `ovf` = 0, `fifo_level` = 1.
